// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator / measurement pair:
// the common counter width and the measurement FSM encoding.
package pwm_pkg;

  localparam int unsigned CNT_W_DEF = 13;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2
  } meas_state_e;

endpackage

// File: rtl/pwm_measure_sync_edge.sv
// Multi-stage synchroniser for an asynchronous level input, followed by
// a rising-edge detector on the synchronised level.
module sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic s_o,
  output logic rise_o
);

  logic [STAGES-1:0] sync_q;
  logic              s_dly_q;

  // Shift the raw input through the synchroniser and keep one extra delayed copy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q  <= '0;
      s_dly_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[STAGES-2:0], d_i};
      s_dly_q <= sync_q[STAGES-1];
    end
  end

  assign s_o    = sync_q[STAGES-1];
  assign rise_o = sync_q[STAGES-1] & ~s_dly_q;

endmodule

// File: rtl/pwm_measure.sv
// Measures high time, dead (both-low) time and period of a PWM pair in core
// clock ticks, presenting each completed cycle through a valid/ready register.
module pwm_measure
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             signal,
  input  logic             signal_b,
  input  logic             meas_ready,
  output logic             meas_valid,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] dead_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic             sat,
  output logic             overlap_err,
  output logic             overrun_err,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    if (inc && (v != CNT_MAX)) begin
      return v + CNT_ONE;
    end else begin
      return v;
    end
  endfunction

  logic s_sig;
  logic s_sigb;
  logic sig_rise;
  logic sigb_rise_unused;

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sig (
    .clk    (clk),
    .reset  (reset),
    .d_i    (signal),
    .s_o    (s_sig),
    .rise_o (sig_rise)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sigb (
    .clk    (clk),
    .reset  (reset),
    .d_i    (signal_b),
    .s_o    (s_sigb),
    .rise_o (sigb_rise_unused)
  );

  meas_state_e      state_q;
  logic [CNT_W-1:0] period_q;
  logic [CNT_W-1:0] high_q;
  logic [CNT_W-1:0] dead_q;

  logic [CNT_W-1:0] period_d;
  logic [CNT_W-1:0] high_d;
  logic [CNT_W-1:0] dead_d;
  logic             capture_s;
  logic             res_sat_s;

  // Saturating next counts and capture qualification for the current cycle
  always_comb begin
    period_d  = sat_inc(period_q, 1'b1);
    high_d    = sat_inc(high_q, s_sig);
    dead_d    = sat_inc(dead_q, ~s_sig & ~s_sigb);
    capture_s = en && (state_q == ST_RUN) && sig_rise;
    res_sat_s = (period_q == CNT_MAX) || (high_q == CNT_MAX) || (dead_q == CNT_MAX);
  end

  // Measurement FSM, counters, result register, handshake and error flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      period_q    <= '0;
      high_q      <= '0;
      dead_q      <= '0;
      meas_valid  <= 1'b0;
      high_cnt    <= '0;
      dead_cnt    <= '0;
      period_cnt  <= '0;
      sat         <= 1'b0;
      overlap_err <= 1'b0;
      overrun_err <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      timeout <= 1'b0;

      // An acceptance in the capture cycle frees the register, so no bubble.
      if (capture_s && (!meas_valid || meas_ready)) begin
        meas_valid <= 1'b1;
        high_cnt   <= high_q;
        dead_cnt   <= dead_q;
        period_cnt <= period_q;
        sat        <= res_sat_s;
      end else if (capture_s) begin
        overrun_err <= 1'b1;
      end else if (meas_valid && meas_ready) begin
        meas_valid <= 1'b0;
      end

      if ((state_q == ST_RUN) && s_sig && s_sigb) begin
        overlap_err <= 1'b1;
      end

      if (!en) begin
        state_q  <= ST_IDLE;
        period_q <= '0;
        high_q   <= '0;
        dead_q   <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            state_q  <= ST_ARM;
            period_q <= '0;
            high_q   <= '0;
            dead_q   <= '0;
          end
          ST_ARM: begin
            if (sig_rise) begin
              state_q  <= ST_RUN;
              period_q <= CNT_ONE;
              high_q   <= CNT_ONE;
              dead_q   <= '0;
            end
          end
          ST_RUN: begin
            if (sig_rise) begin
              period_q <= CNT_ONE;
              high_q   <= CNT_ONE;
              dead_q   <= '0;
            end else if (period_q == CNT_MAX) begin
              timeout  <= 1'b1;
              state_q  <= ST_ARM;
              period_q <= '0;
              high_q   <= '0;
              dead_q   <= '0;
            end else begin
              period_q <= period_d;
              high_q   <= high_d;
              dead_q   <= dead_d;
            end
          end
          default: begin
            state_q  <= ST_IDLE;
            period_q <= '0;
            high_q   <= '0;
            dead_q   <= '0;
          end
        endcase
      end
    end
  end

endmodule
